// File: rtl/pipe_mdu.sv
// pipe_mdu -- multi-cycle multiply/divide unit with HI/LO registers for the
// execute stage of the 5-stage pipeline.
//
// Multiply (MULT/MULTU) produces the 2*WIDTH-bit product MUL_LAT edges after
// acceptance. Divide (DIV/DIVU) takes operand magnitudes on the first edge,
// then runs a restoring divider for WIDTH edges, one quotient bit per edge.
// hi/lo are written on the edge that enters FIN, so they already hold the
// result during the single done cycle.
//
// Optional feature: define MDU_EARLY_OUT_EN to finish a divide two edges
// after acceptance when |a| < |b| or a == 0 (quotient 0, remainder a).
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   start      issue request from the E stage, qualified by op
//   op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b       rs / rt operands
//   flush      abort the in-flight operation (flushE)
//   hi_we      mthi write of wdata
//   lo_we      mtlo write of wdata
//   wdata      mthi/mtlo data
//   busy       operation in flight (MUL or DIV state)
//   stall_req  hold F/D/E stages
//   done       one-cycle completion pulse
//   div_zero   pulses with done when a divide had divisor 0
//   hi, lo     HI / LO registers
module pipe_mdu #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    localparam int              CNT_W        = $clog2(WIDTH + MUL_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    // Control state
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             divInit;   // first DIV edge: load magnitudes

    // Latched operation
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             opSigned;
    logic             opDiv;

    // Divider datapath
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic             negQ;
    logic             negR;
    logic             earlyHit;

    logic             accept;
    logic             finish;
    logic [WIDTH-1:0] resHi;
    logic [WIDTH-1:0] resLo;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic [2*WIDTH-1:0] extA;
    logic [2*WIDTH-1:0] extB;
    logic [2*WIDTH-1:0] mulProd;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   stepRem;
    logic [WIDTH-1:0]   stepQuo;
    logic [WIDTH-1:0]   divQ;
    logic [WIDTH-1:0]   divR;
    logic               divByZero;

    assign accept = (state == ST_IDLE) && start && !flush;

    assign magA = (opSigned && opA[WIDTH-1]) ? -opA : opA;
    assign magB = (opSigned && opB[WIDTH-1]) ? -opB : opB;

    // Sign- or zero-extend to 2*WIDTH; the low 2*WIDTH bits of the product
    // are then correct for both signed and unsigned multiply.
    assign extA    = {{WIDTH{opSigned & opA[WIDTH-1]}}, opA};
    assign extB    = {{WIDTH{opSigned & opB[WIDTH-1]}}, opB};
    assign mulProd = extA * extB;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits.
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor};
    assign stepRem = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign stepQuo = {quo[WIDTH-2:0], ~diff[WIDTH]};

    // MIN / -1 needs no special case: the magnitude quotient 2^(W-1) with a
    // positive sign wraps back to MIN.
    assign divQ      = negQ ? -stepQuo : stepQuo;
    assign divR      = negR ? -stepRem : stepRem;
    assign divByZero = (opB == '0);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        finish = 1'b0;
        resHi  = mulProd[2*WIDTH-1:WIDTH];
        resLo  = mulProd[WIDTH-1:0];
        case (state)
            ST_MUL: finish = !flush && (cnt == '0);
            ST_DIV: begin
                finish = !flush && !divInit && (earlyHit || (cnt == '0));
                if (divByZero) begin
                    resHi = opA;
                    resLo = '1;
                end else if (earlyHit) begin
                    resHi = opA;
                    resLo = '0;
                end else begin
                    resHi = divR;
                    resLo = divQ;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            divInit <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state   <= op[1] ? ST_DIV : ST_MUL;
                        cnt     <= op[1] ? DIV_CNT_INIT : MUL_CNT_INIT;
                        divInit <= 1'b1;
                    end
                end
                ST_MUL: begin
                    if (flush)       state <= ST_IDLE;
                    else if (finish) state <= ST_FIN;
                    else             cnt   <= cnt - CNT_ONE;
                end
                ST_DIV: begin
                    if (flush)        state   <= ST_IDLE;
                    else if (divInit) divInit <= 1'b0;
                    else if (finish)  state   <= ST_FIN;
                    else              cnt     <= cnt - CNT_ONE;
                end
                default: state <= ST_IDLE;   // FIN lasts exactly one cycle
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Operand and divider registers
    // ------------------------------------------------------------------
    // NOTE: datapath registers carry no reset; they are always loaded before
    // being read, and the control state above guards every use.
    always_ff @(posedge clk) begin
        if (accept) begin
            opA      <= a;
            opB      <= b;
            opSigned <= ~op[0];
            opDiv    <= op[1];
        end
        if (state == ST_DIV) begin
            if (divInit) begin
                divisor <= magB;
                rem     <= '0;
                quo     <= magA;
                negQ    <= opSigned & (opA[WIDTH-1] ^ opB[WIDTH-1]);
                negR    <= opSigned & opA[WIDTH-1];
            end else begin
                rem <= stepRem;
                quo <= stepQuo;
            end
        end
    end

`ifdef MDU_EARLY_OUT_EN
    logic earlyOut;

    // Decided on the magnitude edge; divide by zero never takes the shortcut.
    always_ff @(posedge clk) begin
        if (state == ST_DIV && divInit) begin
            earlyOut <= !divByZero && ((magA < magB) || (opA == '0));
        end
    end

    assign earlyHit = earlyOut;
`else
    assign earlyHit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // HI / LO: a direct mthi/mtlo write beats the result for that register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (hi_we)       hi <= wdata;
            else if (finish) hi <= resHi;
            if (lo_we)       lo <= wdata;
            else if (finish) lo <= resLo;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy      = (state == ST_MUL) || (state == ST_DIV);
    assign done      = (state == ST_FIN);
    assign div_zero  = done && opDiv && divByZero;
    // Combinational so the issuing instruction is held in its issue cycle.
    assign stall_req = accept || busy;

endmodule

// File: tb/tb_pipe_mdu.sv
// tb_pipe_mdu -- directed self-checking bench for pipe_mdu (WIDTH=32,
// MUL_LAT=3). Inputs are driven and outputs sampled on the falling edge.
module tb_pipe_mdu;

    localparam int W  = 32;
    localparam int ML = 3;
    localparam int DL = W + 1;
`ifdef MDU_EARLY_OUT_EN
    localparam int EARLY_LAT = 2;
`else
    localparam int EARLY_LAT = W + 1;
`endif

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         hiWe;
    logic         loWe;
    logic [W-1:0] wdata;
    logic         busy;
    logic         stallReq;
    logic         done;
    logic         divZero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks   = 0;
    int failures = 0;

    pipe_mdu #(.WIDTH(W), .MUL_LAT(ML)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .hi_we     (hiWe),
        .lo_we     (loWe),
        .wdata     (wdata),
        .busy      (busy),
        .stall_req (stallReq),
        .done      (done),
        .div_zero  (divZero),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Raise start on a falling edge, confirm the issue-cycle stall, let the
    // accepting edge T0 pass and return on the falling edge after it.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input string tag);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        #1 check({tag, ".stall_issue"}, 64'(stallReq), 64'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges after T0 until done is seen; bounded at 100.
    task automatic waitDone(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int lat;
    int doneSeen;

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        flush = 1'b0;
        hiWe  = 1'b0;
        loWe  = 1'b0;
        wdata = '0;

        #2;
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.hi",   64'(hi),   64'd0);
        check("rst.lo",   64'(lo),   64'd0);
        @(negedge clk);
        rst = 1'b1;

        // MULT -3 * 7 = -21
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, "mult");
        check("mult.busy", 64'(busy), 64'd1);
        waitDone(lat);
        check("mult.lat",   64'(lat),      64'(ML));
        check("mult.hi",    64'(hi),       64'hFFFF_FFFF);
        check("mult.lo",    64'(lo),       64'hFFFF_FFEB);
        check("mult.dz",    64'(divZero),  64'd0);
        check("mult.busy_fin",  64'(busy),     64'd0);
        check("mult.stall_fin", 64'(stallReq), 64'd0);
        @(negedge clk);
        check("mult.done_pulse", 64'(done), 64'd0);

        // DIVU 100 / 7
        issue(OP_DIVU, 32'd100, 32'd7, "divu");
        waitDone(lat);
        check("divu.lat", 64'(lat),     64'(DL));
        check("divu.lo",  64'(lo),      64'd14);
        check("divu.hi",  64'(hi),      64'd2);
        check("divu.dz",  64'(divZero), 64'd0);

        // DIVU 3 / 7: early-out candidate
        issue(OP_DIVU, 32'd3, 32'd7, "divu_small");
        waitDone(lat);
        check("divu_small.lat", 64'(lat), 64'(EARLY_LAT));
        check("divu_small.lo",  64'(lo),  64'd0);
        check("divu_small.hi",  64'(hi),  64'd3);

        // DIV -7 / 2 = -3 rem -1
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg");
        waitDone(lat);
        check("div_neg.lat", 64'(lat), 64'(DL));
        check("div_neg.lo",  64'(lo),  64'hFFFF_FFFD);
        check("div_neg.hi",  64'(hi),  64'hFFFF_FFFF);

        // DIV MIN / -1
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_min");
        waitDone(lat);
        check("div_min.lo", 64'(lo), 64'h8000_0000);
        check("div_min.hi", 64'(hi), 64'd0);

        // DIV 5 / 0
        issue(OP_DIV, 32'd5, 32'd0, "div0");
        waitDone(lat);
        check("div0.lat", 64'(lat),     64'(DL));
        check("div0.dz",  64'(divZero), 64'd1);
        check("div0.lo",  64'(lo),      64'hFFFF_FFFF);
        check("div0.hi",  64'(hi),      64'd5);
        @(negedge clk);
        check("div0.dz_pulse", 64'(divZero), 64'd0);

        // mthi/mtlo in IDLE
        hiWe  = 1'b1;
        wdata = 32'hAA;
        @(negedge clk);
        hiWe  = 1'b0;
        loWe  = 1'b1;
        wdata = 32'hBB;
        @(negedge clk);
        loWe  = 1'b0;
        check("mthi.hi", 64'(hi), 64'hAA);
        check("mtlo.lo", 64'(lo), 64'hBB);

        // Flush a divide during the 11th cycle after T0
        issue(OP_DIVU, 32'd100, 32'd7, "flush");
        repeat (10) @(negedge clk);
        check("flush.busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush.busy_after", 64'(busy), 64'd0);
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) doneSeen++;
            @(negedge clk);
        end
        check("flush.no_done", 64'(doneSeen), 64'd0);
        check("flush.hi", 64'(hi), 64'hAA);
        check("flush.lo", 64'(lo), 64'hBB);

        // start together with flush in IDLE is not accepted
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        op    = OP_MULT;
        a     = 32'd9;
        b     = 32'd9;
        #1 check("sflush.stall", 64'(stallReq), 64'd0);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("sflush.busy", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        check("sflush.hi", 64'(hi), 64'hAA);

        // Back-to-back: start held through FIN is only taken in IDLE
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, "b2b1");
        waitDone(lat);
        check("b2b1.hi", 64'(hi), 64'd1);
        check("b2b1.lo", 64'(lo), 64'hFFFF_FFFE);
        start = 1'b1;
        op    = OP_MULT;
        a     = 32'd2;
        b     = 32'd3;
        #1 check("b2b.stall_fin", 64'(stallReq), 64'd0);
        @(negedge clk);
        check("b2b.busy_idle",  64'(busy),     64'd0);
        check("b2b.stall_idle", 64'(stallReq), 64'd1);
        @(negedge clk);
        start = 1'b0;
        check("b2b.busy_acc", 64'(busy), 64'd1);
        waitDone(lat);
        check("b2b2.lat", 64'(lat), 64'(ML));
        check("b2b2.lo",  64'(lo),  64'd6);
        check("b2b2.hi",  64'(hi),  64'd0);

        // mtlo coincident with the multiply result write
        issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000, "mtlo_fin");
        repeat (ML - 1) @(negedge clk);
        loWe  = 1'b1;
        wdata = 32'h5555;
        @(negedge clk);
        loWe  = 1'b0;
        check("mtlo_fin.done", 64'(done), 64'd1);
        check("mtlo_fin.lo",   64'(lo),   64'h5555);
        check("mtlo_fin.hi",   64'(hi),   64'd1);

        // Asynchronous reset in the middle of a multiply
        issue(OP_MULT, 32'd2, 32'd3, "rst_mid");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid.busy", 64'(busy), 64'd0);
        check("rst_mid.hi",   64'(hi),   64'd0);
        check("rst_mid.lo",   64'(lo),   64'd0);
        @(negedge clk);
        rst   = 1'b1;
        hiWe  = 1'b1;
        wdata = 32'h1234;
        @(negedge clk);
        hiWe  = 1'b0;
        check("post_rst.hi",   64'(hi),   64'h1234);
        check("post_rst.lo",   64'(lo),   64'd0);
        check("post_rst.busy", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        check("post_rst.no_done", 64'(done), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_mdu.md
Name: pipe_mdu

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers, attached to the execute stage of the 5-stage pipeline.
- Successor to the single-cycle ALU path. It is generalised in operand width and multiply latency, and adds signed/unsigned divide, a stall handshake into the hazard logic, and flush abort.
- It occupies the E stage while busy. It holds the pipeline through stall_req and publishes HI/LO for mfhi/mflo.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- MUL_LAT, 3, multiply latency in clock edges from start acceptance to result; legal range 1..8.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- start  in  1  issue request from E stage, qualified by op
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  WIDTH  rs operand (dividend / multiplicand)
- b  in  WIDTH  rt operand (divisor / multiplier)
- flush  in  1  abort in-flight operation (flushE)
- hi_we  in  1  mthi write
- lo_we  in  1  mtlo write
- wdata  in  WIDTH  mthi/mtlo data
- busy  out  1  operation in flight
- stall_req  out  1  hold F/D/E stages
- done  out  1  one-cycle completion pulse
- div_zero  out  1  one-cycle pulse with done when divisor was 0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset, asynchronous on rst=0:
  - state=IDLE; hi=0, lo=0; busy=0, done=0, div_zero=0.
  - Any in-flight operation is discarded.
- FSM states: IDLE, MUL, DIV, FIN.
- IDLE:
  - start=1 and flush=0 at edge T0 latches a, b, op.
  - op[1]=0 goes to MUL; op[1]=1 goes to DIV.
  - start is ignored in every other state.
- MUL:
  - Computes the 2*WIDTH-bit product, signed for op=00 and unsigned for op=01.
  - Moves to FIN at edge T0+MUL_LAT.
- DIV:
  - Edge T0+1: take operand magnitudes.
  - Next WIDTH edges: restoring division, one quotient bit per edge.
  - Moves to FIN at edge T0+WIDTH+1.
  - Signed sign rules: quotient sign = a[W-1]^b[W-1]; remainder sign = a[W-1].
  - MIN/-1 yields lo=MIN, hi=0, with no trap.
  - Divide by zero: lo=all ones, hi=a, div_zero pulses with done.
- FIN is the single cycle in which done=1.
  - hi/lo already hold the new result in this cycle: multiply gives hi=upper half, lo=lower half; divide gives lo=quotient, hi=remainder.
  - Next edge returns to IDLE.
  - A start in FIN is ignored; the E-stage instruction advances first.
- busy=1 in MUL and DIV, and 0 in IDLE and FIN.
- stall_req = (start & ~flush & IDLE) | busy. It is combinational, so the issuing instruction is stalled in its issue cycle. It is released in the FIN cycle.
- Flush:
  - In MUL or DIV, the next edge goes to IDLE.
  - hi/lo are unchanged; done and div_zero are not asserted.
  - flush with start in IDLE: flush wins, and the op is not accepted.
- mthi/mtlo:
  - hi_we/lo_we write wdata at the edge in any state.
  - If the write coincides with a result write, the direct write wins for that register. The other register still takes the result.
- Back-to-back ops: a new start is accepted in the first IDLE cycle after FIN.

Optional Feature:
- Macro MDU_EARLY_OUT_EN.
- When defined, a divide whose |a| < |b|, or whose a=0, goes from DIV to FIN at edge T0+2.
  - Results: quotient 0, remainder a.
  - Divide by zero is unaffected.
- When undefined, divide latency is fixed at WIDTH+1 edges.
- Multiply behaviour is identical either way.

Test Plan:
- MULT a=0xFFFFFFFD, b=7, WIDTH=32, MUL_LAT=3 -> stall_req=1 in issue cycle; done at T0+3; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIVU a=100, b=7 -> done at T0+33; lo=14, hi=2, div_zero=0. With MDU_EARLY_OUT_EN, DIVU a=3, b=7 -> done at T0+2; lo=0, hi=3.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV a=5, b=0 -> done and div_zero both pulse at T0+33; lo=0xFFFFFFFF, hi=5.
- Divide with flush=1 at T0+10, prior hi=0xAA, lo=0xBB -> busy=0 after T0+11; no done; hi=0xAA, lo=0xBB. Simultaneous start+flush -> busy stays 0.
- rst=0 mid-MULT -> busy, hi, lo are 0 immediately, without waiting for a clock. Then hi_we=1, wdata=0x1234 -> hi=0x1234 next edge. lo_we on the FIN cycle of a multiply -> lo=wdata, hi=product upper half.
